// File: rtl/i2c_globals_pkg.sv
// Shared I2C widths, transfer direction and the slave responder state type.
package i2c_globals_pkg;

    localparam int CHAR_LENGTH            = 8;
    localparam int REGISTER_ADDRESS_WIDTH = 8;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } read_write_e;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG_ADDR,
        REG_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_slave_state_e;

endpackage

// File: rtl/i2c_bus_condition_detect.sv
// Synchronizes raw SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_bus_condition_detect (
    input  logic pclk,
    input  logic areset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge pclk) begin
        if (areset) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    // bit 1 is the synchronized level, bit 2 is that level one pclk earlier
    assign sda_o      = sda_q[1];
    assign scl_rise_o = scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] & scl_q[2];
    assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave with an internal register file, auto-incrementing pointer and write strobe.
// Define I2C_SLAVE_GENERAL_CALL_EN to also acknowledge the general-call address 7'h00 (write).
module i2c_slave_responder
    import i2c_globals_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h50,
    parameter int         NO_OF_REGS    = 16
) (
    input  logic                              pclk,
    input  logic                              areset,
    input  logic                              scl_i,
    input  logic                              sda_i,
    output logic                              sda_oe,
    output logic                              wr_strobe,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr,
    output logic [CHAR_LENGTH-1:0]            wr_data,
    output logic                              busy
);

    localparam int PTR_W = (NO_OF_REGS > 1) ? $clog2(NO_OF_REGS) : 1;
    localparam logic [3:0] BYTE_BITS = 4'(CHAR_LENGTH);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    localparam logic GC_EN = 1'b1;
`else
    localparam logic GC_EN = 1'b0;
`endif

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_condition_detect u_detect (
        .pclk       (pclk),
        .areset     (areset),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    i2c_slave_state_e                  state_q;
    read_write_e                       rw_q;
    logic [3:0]                        bit_cnt_q;
    logic [CHAR_LENGTH-1:0]            shift_q;
    logic [PTR_W-1:0]                  ptr_q;
    logic [CHAR_LENGTH-1:0]            regs_q [NO_OF_REGS];
    logic                              sda_oe_q;
    logic                              wr_strobe_q;
    logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr_q;
    logic [CHAR_LENGTH-1:0]            wr_data_q;
    logic                              busy_q;

    logic                   addr_match;
    logic [CHAR_LENGTH-1:0] rd_byte;

    assign addr_match = (shift_q[7:1] == SLAVE_ADDRESS) ||
                        (GC_EN && (shift_q[7:1] == 7'h00) && (shift_q[0] == 1'b0));
    assign rd_byte    = regs_q[ptr_q];

    always_ff @(posedge pclk) begin
        if (areset) begin
            state_q     <= IDLE;
            rw_q        <= WRITE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NO_OF_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            // bus conditions win over any SCL edge seen in the same cycle
            if (stop_det) begin
                state_q   <= IDLE;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                bit_cnt_q <= '0;
            end else if (start_det) begin
                state_q   <= ADDR;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
            end else if (scl_rise) begin
                case (state_q)
                    ADDR, REG_ADDR, WR_DATA: begin
                        shift_q   <= {shift_q[CHAR_LENGTH-2:0], sda_s};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                    RD_DATA: bit_cnt_q <= bit_cnt_q + 4'd1;
                    RD_ACK: begin
                        ptr_q <= ptr_q + 1'b1;
                        if (sda_s) state_q <= IGNORE;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    ADDR: if (bit_cnt_q == BYTE_BITS) begin
                        bit_cnt_q <= '0;
                        if (addr_match) begin
                            state_q  <= ADDR_ACK;
                            sda_oe_q <= 1'b1;
                            busy_q   <= 1'b1;
                            rw_q     <= read_write_e'(shift_q[0]);
                        end else begin
                            state_q <= IGNORE;
                            busy_q  <= 1'b0;
                        end
                    end
                    ADDR_ACK: if (rw_q == READ) begin
                        state_q  <= RD_DATA;
                        sda_oe_q <= ~rd_byte[CHAR_LENGTH-1];
                        shift_q  <= {rd_byte[CHAR_LENGTH-2:0], 1'b0};
                    end else begin
                        state_q  <= REG_ADDR;
                        sda_oe_q <= 1'b0;
                    end
                    REG_ADDR: if (bit_cnt_q == BYTE_BITS) begin
                        bit_cnt_q <= '0;
                        ptr_q     <= shift_q[PTR_W-1:0];
                        sda_oe_q  <= 1'b1;
                        state_q   <= REG_ACK;
                    end
                    REG_ACK: begin
                        sda_oe_q <= 1'b0;
                        state_q  <= WR_DATA;
                    end
                    WR_DATA: if (bit_cnt_q == BYTE_BITS) begin
                        bit_cnt_q     <= '0;
                        regs_q[ptr_q] <= shift_q;
                        wr_strobe_q   <= 1'b1;
                        wr_addr_q     <= REGISTER_ADDRESS_WIDTH'(ptr_q);
                        wr_data_q     <= shift_q;
                        sda_oe_q      <= 1'b1;
                        state_q       <= WR_ACK;
                    end
                    WR_ACK: begin
                        sda_oe_q <= 1'b0;
                        ptr_q    <= ptr_q + 1'b1;
                        state_q  <= WR_DATA;
                    end
                    RD_DATA: if (bit_cnt_q == BYTE_BITS) begin
                        bit_cnt_q <= '0;
                        sda_oe_q  <= 1'b0;
                        state_q   <= RD_ACK;
                    end else begin
                        sda_oe_q <= ~shift_q[CHAR_LENGTH-1];
                        shift_q  <= {shift_q[CHAR_LENGTH-2:0], 1'b0};
                    end
                    // only reached after a master ACK; a NACK left for IGNORE on the rise
                    RD_ACK: begin
                        state_q  <= RD_DATA;
                        sda_oe_q <= ~rd_byte[CHAR_LENGTH-1];
                        shift_q  <= {rd_byte[CHAR_LENGTH-2:0], 1'b0};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bus-level master tasks plus a register-file reference model.
module tb_i2c_slave_responder;
    import i2c_globals_pkg::*;

    localparam int         Q    = 6;
    localparam int         NREG = 16;
    localparam logic [6:0] SA   = 7'h50;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    localparam int GC_ACKS = 1;
`else
    localparam int GC_ACKS = 0;
`endif

    logic pclk = 1'b0;
    logic areset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic scl_i, sda_i;
    logic sda_oe, wr_strobe, busy;
    logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr;
    logic [CHAR_LENGTH-1:0] wr_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    i2c_slave_responder #(.SLAVE_ADDRESS(SA), .NO_OF_REGS(NREG)) dut (
        .pclk(pclk), .areset(areset), .scl_i(scl_i), .sda_i(sda_i),
        .sda_oe(sda_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    int oe_cycles = 0;
    logic [7:0] stb_addr[$];
    logic [7:0] stb_data[$];
    always @(negedge pclk) begin
        if (sda_oe === 1'b1) oe_cycles = oe_cycles + 1;
        if (wr_strobe === 1'b1) begin
            stb_addr.push_back(wr_addr);
            stb_data.push_back(wr_data);
        end
    end

    // reference model: register contents and pointer as a master would see them
    logic [7:0] m_regs [NREG];
    int m_ptr;
    logic [7:0] wr_buf [8];
    logic [7:0] rd_buf [8];

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic clk_bit(input logic b, output logic r);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        r = sda_i;    tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
        clk_bit(1'b1, r);
        ack = (r === 1'b0);
    endtask

    task automatic read_byte(input bit master_ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            d[i] = r;
        end
        clk_bit(master_ack ? 1'b0 : 1'b1, r);
    endtask

    task automatic xfer_write(input logic [6:0] a, input int n, output int acks);
        bit ack;
        acks = 0;
        bus_start();
        write_byte({a, 1'b0}, ack); acks += int'(ack);
        for (int i = 0; i < n; i++) begin
            write_byte(wr_buf[i], ack); acks += int'(ack);
        end
    endtask

    task automatic xfer_read(input bit pset, input logic [7:0] p, input int k, output int acks);
        bit ack;
        acks = 0;
        if (pset) begin
            bus_start();
            write_byte({SA, 1'b0}, ack); acks += int'(ack);
            write_byte(p, ack); acks += int'(ack);
        end
        bus_start();
        write_byte({SA, 1'b1}, ack); acks += int'(ack);
        for (int i = 0; i < k; i++) read_byte(i < k - 1, rd_buf[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick(4);
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        n_cmp++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_wr_strobe got %b want 0", wr_strobe); end
        n_cmp++; if (wr_addr !== 8'h00) begin n_err++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
        n_cmp++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
        areset = 1'b0;
        model_reset();
        tick(4);
    endtask

    task automatic test_basic_write();
        int acks;
        wr_buf[0] = 8'h03; wr_buf[1] = 8'hA5;
        xfer_write(SA, 2, acks);
        n_cmp++; if (acks != 3) begin n_err++; $display("FAIL basic_acks got %0d want 3", acks); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_mid got %b want 1", busy); end
        bus_stop();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_stop got %b want 0", busy); end
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL basic_oe_stop got %b want 0", sda_oe); end
        n_cmp++;
        if (stb_addr.size() != 1) begin
            n_err++; $display("FAIL basic_strobes got %0d want 1", stb_addr.size());
        end else if (stb_addr[0] !== 8'h03 || stb_data[0] !== 8'hA5) begin
            n_err++; $display("FAIL basic_strobe got %h/%h want 03/a5", stb_addr[0], stb_data[0]);
        end
        stb_addr.delete(); stb_data.delete();
        m_regs[3] = 8'hA5; m_ptr = 4;
    endtask

    task automatic test_wrap();
        int acks;
        wr_buf[0] = 8'h0F; wr_buf[1] = 8'h11; wr_buf[2] = 8'h22;
        xfer_write(SA, 3, acks);
        bus_stop();
        n_cmp++; if (acks != 4) begin n_err++; $display("FAIL wrap_acks got %0d want 4", acks); end
        n_cmp++;
        if (stb_addr.size() != 2) begin
            n_err++; $display("FAIL wrap_strobes got %0d want 2", stb_addr.size());
        end else if (stb_addr[0] !== 8'd15 || stb_addr[1] !== 8'd0 ||
                     stb_data[0] !== 8'h11 || stb_data[1] !== 8'h22) begin
            n_err++; $display("FAIL wrap_strobe got %0d,%0d/%h,%h want 15,0/11,22",
                              stb_addr[0], stb_addr[1], stb_data[0], stb_data[1]);
        end
        stb_addr.delete(); stb_data.delete();
        m_regs[15] = 8'h11; m_regs[0] = 8'h22; m_ptr = 1;
    endtask

    task automatic test_read_back();
        int acks;
        xfer_read(1'b1, 8'h03, 2, acks);
        n_cmp++; if (acks != 3) begin n_err++; $display("FAIL rd_acks got %0d want 3", acks); end
        n_cmp++; if (rd_buf[0] !== 8'hA5) begin n_err++; $display("FAIL rd_byte0 got %h want a5", rd_buf[0]); end
        n_cmp++; if (rd_buf[1] !== m_regs[4]) begin n_err++; $display("FAIL rd_byte1 got %h want %h", rd_buf[1], m_regs[4]); end
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rd_release_after_nack got %b want 0", sda_oe); end
        bus_stop();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_stop got %b want 0", busy); end
        m_ptr = 5;
    endtask

    task automatic test_mismatch();
        int acks, oe0;
        oe0 = oe_cycles;
        wr_buf[0] = 8'h00; wr_buf[1] = 8'h77;
        xfer_write(7'h51, 2, acks);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mis_busy got %b want 0", busy); end
        bus_stop();
        n_cmp++; if (acks != 0) begin n_err++; $display("FAIL mis_acks got %0d want 0", acks); end
        n_cmp++; if (oe_cycles != oe0) begin n_err++; $display("FAIL mis_oe_cycles got %0d want 0", oe_cycles - oe0); end
        n_cmp++; if (stb_addr.size() != 0) begin n_err++; $display("FAIL mis_strobes got %0d want 0", stb_addr.size()); end
        stb_addr.delete(); stb_data.delete();
    endtask

    task automatic test_reset_mid();
        bit ack;
        logic r;
        int acks;
        bus_start();
        write_byte({SA, 1'b0}, ack);
        write_byte(8'h07, ack);
        for (int i = 0; i < 4; i++) clk_bit(i[0], r);
        areset = 1'b1;
        tick(3);
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rstmid_oe got %b want 0", sda_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL rstmid_state got %0d want IDLE", dut.state_q); end
        areset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) clk_bit(1'b1, r);
        bus_stop();
        n_cmp++; if (stb_addr.size() != 0) begin n_err++; $display("FAIL rstmid_strobes got %0d want 0", stb_addr.size()); end
        stb_addr.delete(); stb_data.delete();
        wr_buf[0] = 8'h02; wr_buf[1] = 8'h5C;
        xfer_write(SA, 2, acks);
        bus_stop();
        n_cmp++; if (acks != 3) begin n_err++; $display("FAIL rstmid_next_acks got %0d want 3", acks); end
        n_cmp++;
        if (stb_addr.size() != 1 || stb_addr[0] !== 8'h02 || stb_data[0] !== 8'h5C) begin
            n_err++; $display("FAIL rstmid_next_strobe got %0d entries want one 02/5c", stb_addr.size());
        end
        stb_addr.delete(); stb_data.delete();
        m_regs[2] = 8'h5C; m_ptr = 3;
    endtask

    task automatic test_general_call();
        int acks;
        xfer_write(7'h00, 0, acks);
        bus_stop();
        n_cmp++; if (acks != GC_ACKS) begin n_err++; $display("FAIL gc_acks got %0d want %0d", acks, GC_ACKS); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL gc_busy_stop got %b want 0", busy); end
    endtask

    task automatic test_random();
        int acks, n, k, exp_acks;
        bit pset;
        logic [7:0] p, ea;
        for (int it = 0; it < 16; it++) begin
            p = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(1, 4);
                wr_buf[0] = p;
                for (int j = 0; j < n; j++) wr_buf[j + 1] = 8'($urandom);
                xfer_write(SA, n + 1, acks);
                bus_stop();
                n_cmp++; if (acks != n + 2) begin n_err++; $display("FAIL rnd_wr_acks it%0d got %0d want %0d", it, acks, n + 2); end
                n_cmp++;
                if (stb_addr.size() != n) begin
                    n_err++; $display("FAIL rnd_wr_strobes it%0d got %0d want %0d", it, stb_addr.size(), n);
                end else begin
                    for (int j = 0; j < n; j++) begin
                        ea = 8'((int'(p) + j) % NREG);
                        if (stb_addr[j] !== ea || stb_data[j] !== wr_buf[j + 1]) begin
                            n_err++;
                            $display("FAIL rnd_wr_strobe it%0d byte%0d got %h/%h want %h/%h",
                                     it, j, stb_addr[j], stb_data[j], ea, wr_buf[j + 1]);
                        end
                    end
                end
                stb_addr.delete(); stb_data.delete();
                for (int j = 0; j < n; j++) m_regs[(int'(p) + j) % NREG] = wr_buf[j + 1];
                m_ptr = (int'(p) + n) % NREG;
            end else begin
                pset = 1'($urandom_range(0, 1));
                k = $urandom_range(1, 4);
                if (pset) m_ptr = int'(p) % NREG;
                exp_acks = pset ? 3 : 1;
                xfer_read(pset, p, k, acks);
                bus_stop();
                n_cmp++; if (acks != exp_acks) begin n_err++; $display("FAIL rnd_rd_acks it%0d got %0d want %0d", it, acks, exp_acks); end
                for (int j = 0; j < k; j++) begin
                    n_cmp++;
                    if (rd_buf[j] !== m_regs[(m_ptr + j) % NREG]) begin
                        n_err++;
                        $display("FAIL rnd_rd_byte it%0d byte%0d got %h want %h",
                                 it, j, rd_buf[j], m_regs[(m_ptr + j) % NREG]);
                    end
                end
                m_ptr = (m_ptr + k) % NREG;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_write();
        test_wrap();
        test_read_back();
        test_mismatch();
        test_reset_mid();
        test_general_call();
        test_random();
        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
